// File: rtl/memaccess_if.sv
// ---------------------------------------------------------------------------
// memaccess_if : execute / data-memory / writeback / forwarding bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface memaccess_if;
   logic        ma_vld;
   logic        ma_rdy;
   logic [31:0] ma_inst;
   logic [31:0] ma_dat;
   logic [31:0] ma_rd2;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdat;
   logic        dm_gnt;
   logic        dm_rvld;
   logic [31:0] dm_rdat;
   logic        wb_vld;
   logic [31:0] wb_inst;
   logic [31:0] wb_dat;
   logic        wb_err;
   logic        id_fwd_we;
   logic [4:0]  id_fwd_dst;
   logic [31:0] id_fwd_dat;

   // Stage side.
   modport master (
      input  ma_vld, ma_inst, ma_dat, ma_rd2, dm_gnt, dm_rvld, dm_rdat,
      output ma_rdy, dm_req, dm_we, dm_addr, dm_be, dm_wdat,
      output wb_vld, wb_inst, wb_dat, wb_err, id_fwd_we, id_fwd_dst, id_fwd_dat
   );

   // Execute, memory and writeback/decode side.
   modport slave (
      output ma_vld, ma_inst, ma_dat, ma_rd2, dm_gnt, dm_rvld, dm_rdat,
      input  ma_rdy, dm_req, dm_we, dm_addr, dm_be, dm_wdat,
      input  wb_vld, wb_inst, wb_dat, wb_err, id_fwd_we, id_fwd_dst, id_fwd_dat
   );
endinterface

`default_nettype wire

// File: rtl/memaccess_top.sv
// ---------------------------------------------------------------------------
// memaccess_top : etcpu memory-access stage (load/store over req/gnt/rvld)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memaccess_top (
   input  wire         clk,
   input  wire         rst_n,
   memaccess_if.master bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdat_q, wdat_d;
   logic        wb_vld_q, wb_vld_d;
   logic [31:0] wb_inst_q, wb_inst_d;
   logic [31:0] wb_dat_q, wb_dat_d;
   logic        wb_err_q, wb_err_d;

   logic [6:0]  w_op;
   logic [2:0]  w_f3;
   logic [1:0]  w_off;
   logic        w_is_ls;
   logic        w_misal;
   logic [3:0]  w_be;
   logic [31:0] w_wdat;
   logic [31:0] w_shift;
   logic [31:0] w_load_dat;

   assign w_op    = bus.ma_inst[6:0];
   assign w_f3    = bus.ma_inst[14:12];
   assign w_off   = bus.ma_dat[1:0];
   assign w_is_ls = (w_op == OP_LOAD) || (w_op == OP_STORE);

   // Access size comes from funct3[1:0]: byte, half, word.
   always_comb begin
      w_misal = 1'b0;
      w_be    = 4'b1111;
      w_wdat  = bus.ma_rd2;
      case (w_f3[1:0])
         2'b00: begin
            w_be   = 4'b0001 << w_off;
            w_wdat = {4{bus.ma_rd2[7:0]}};
         end
         2'b01: begin
            w_misal = w_off[0];
            w_be    = 4'b0011 << w_off;
            w_wdat  = {2{bus.ma_rd2[15:0]}};
         end
         default: w_misal = (w_off != 2'b00);
      endcase
   end

   // Lane-align the returned word, then extend per funct3[2] (1 = unsigned).
   assign w_shift = bus.dm_rdat >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (inst_q[13:12])
         2'b00:   w_load_dat = {{24{~inst_q[14] & w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_load_dat = {{16{~inst_q[14] & w_shift[15]}}, w_shift[15:0]};
         default: w_load_dat = w_shift;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdat_d    = wdat_q;
      wb_vld_d  = 1'b0;
      wb_inst_d = wb_inst_q;
      wb_dat_d  = wb_dat_q;
      wb_err_d  = wb_err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ma_vld) begin
               if (w_is_ls && !w_misal) begin
                  state_d = S_REQ;
                  inst_d  = bus.ma_inst;
                  addr_d  = bus.ma_dat;
                  we_d    = (w_op == OP_STORE);
                  be_d    = w_be;
                  wdat_d  = w_wdat;
               end else begin
                  wb_vld_d  = 1'b1;
                  wb_inst_d = bus.ma_inst;
                  wb_dat_d  = w_is_ls ? 32'd0 : bus.ma_dat;
                  wb_err_d  = w_is_ls;
               end
            end
         end
         S_REQ: begin
            if (bus.dm_gnt) begin
               if (we_q) begin
                  state_d   = S_IDLE;
                  wb_vld_d  = 1'b1;
                  wb_inst_d = inst_q;
                  wb_dat_d  = addr_q;
                  wb_err_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.dm_rvld) begin
               state_d   = S_IDLE;
               wb_vld_d  = 1'b1;
               wb_inst_d = inst_q;
               wb_dat_d  = w_load_dat;
               wb_err_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         inst_q    <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdat_q    <= '0;
         wb_vld_q  <= 1'b0;
         wb_inst_q <= '0;
         wb_dat_q  <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdat_q    <= wdat_d;
         wb_vld_q  <= wb_vld_d;
         wb_inst_q <= wb_inst_d;
         wb_dat_q  <= wb_dat_d;
         wb_err_q  <= wb_err_d;
      end
   end

   assign bus.ma_rdy     = (state_q == S_IDLE);
   assign bus.dm_req     = (state_q == S_REQ);
   assign bus.dm_we      = we_q;
   assign bus.dm_addr    = {addr_q[31:2], 2'b00};
   assign bus.dm_be      = be_q;
   assign bus.dm_wdat    = wdat_q;
   assign bus.wb_vld     = wb_vld_q;
   assign bus.wb_inst    = wb_inst_q;
   assign bus.wb_dat     = wb_dat_q;
   assign bus.wb_err     = wb_err_q;
   assign bus.id_fwd_we  = wb_vld_q && (wb_inst_q[6:0] != OP_STORE) &&
                           (wb_inst_q[6:0] != OP_BRANCH) && !wb_err_q &&
                           (wb_inst_q[11:7] != 5'd0);
   assign bus.id_fwd_dst = wb_inst_q[11:7];
   assign bus.id_fwd_dat = wb_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_memaccess_top.sv
// ---------------------------------------------------------------------------
// tb_memaccess_top : randomized self-checking bench for memaccess_top
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memaccess_top;

   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   memaccess_if bus_if();

   memaccess_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd);
      logic [16:0] hi;
      hi = 17'($urandom);
      return {hi, f3, rd, op};
   endfunction

   // Behavioural reference: what the stage must do with one instruction.
   task automatic model(input logic [31:0] inst, input logic [31:0] dat, input logic [31:0] rd2,
                        input logic [31:0] rdat,
                        output bit mem, output bit we, output logic [3:0] be,
                        output logic [31:0] wdat, output logic [31:0] res, output bit err,
                        output bit fwd);
      logic [6:0]  op;
      logic [2:0]  f3;
      int          nbytes;
      int          off;
      bit          is_ls;
      logic [31:0] v;
      op     = inst[6:0];
      f3     = inst[14:12];
      nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off    = int'(dat[1:0]);
      is_ls  = (op == OP_LOAD) || (op == OP_STORE);
      err    = is_ls && ((off % nbytes) != 0);
      mem    = is_ls && !err;
      we     = (op == OP_STORE);
      be     = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1)      wdat = {24'd0, rd2[7:0]} * 32'h0101_0101;
      else if (nbytes == 2) wdat = {16'd0, rd2[15:0]} * 32'h0001_0001;
      else                  wdat = rd2;
      if (err) res = 32'd0;
      else if (op == OP_LOAD) begin
         v = rdat >> (8 * off);
         if (nbytes == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'd256;
         end else if (nbytes == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'd65536;
         end
         res = v;
      end else res = dat;
      fwd = (op != OP_STORE) && (op != OP_BRANCH) && !err && (inst[11:7] != 5'd0);
   endtask

   task automatic check_wb(input logic [31:0] inst, input logic [31:0] res, input bit err,
                           input bit fwd);
      check("wb_vld", bus_if.wb_vld, 1'b1);
      check("wb_inst", bus_if.wb_inst, inst);
      check("wb_dat", bus_if.wb_dat, res);
      check("wb_err", bus_if.wb_err, err);
      check("fwd_we", bus_if.id_fwd_we, fwd);
      check("fwd_dst", bus_if.id_fwd_dst, inst[11:7]);
      check("fwd_dat", bus_if.id_fwd_dat, res);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete transaction from the negedge where the stage is idle.
   task automatic do_op(input logic [31:0] inst, input logic [31:0] dat, input logic [31:0] rd2,
                        input int gdly, input int rdly, input logic [31:0] rdat);
      bit mem, we, err, fwd;
      logic [3:0]  be;
      logic [31:0] wdat, res;
      model(inst, dat, rd2, rdat, mem, we, be, wdat, res, err, fwd);
      check("rdy_idle", bus_if.ma_rdy, 1'b1);
      bus_if.ma_vld  = 1'b1;
      bus_if.ma_inst = inst;
      bus_if.ma_dat  = dat;
      bus_if.ma_rd2  = rd2;
      step();
      bus_if.ma_vld  = 1'b0;
      bus_if.ma_inst = $urandom;
      bus_if.ma_dat  = $urandom;
      bus_if.ma_rd2  = $urandom;
      if (!mem) begin
         check("no_req", bus_if.dm_req, 1'b0);
         check_wb(inst, res, err, fwd);
      end else begin
         for (int i = 0; i <= gdly; i++) begin
            check("req", bus_if.dm_req, 1'b1);
            check("rdy_busy", bus_if.ma_rdy, 1'b0);
            check("wbv_busy", bus_if.wb_vld, 1'b0);
            check("dm_addr", bus_if.dm_addr, {dat[31:2], 2'b00});
            check("dm_we", bus_if.dm_we, we);
            check("dm_be", bus_if.dm_be, be);
            check("dm_wdat", bus_if.dm_wdat, wdat);
            bus_if.dm_gnt  = (i == gdly);
            bus_if.dm_rvld = (i == gdly) ? 1'b0 : 1'($urandom);
            bus_if.dm_rdat = $urandom;
            step();
         end
         bus_if.dm_gnt  = 1'b0;
         bus_if.dm_rvld = 1'b0;
         if (!we) begin
            for (int i = 0; i <= rdly; i++) begin
               check("req_wait", bus_if.dm_req, 1'b0);
               check("rdy_wait", bus_if.ma_rdy, 1'b0);
               check("wbv_wait", bus_if.wb_vld, 1'b0);
               bus_if.dm_rvld = (i == rdly);
               bus_if.dm_rdat = (i == rdly) ? rdat : 32'($urandom);
               step();
            end
            bus_if.dm_rvld = 1'b0;
            bus_if.dm_rdat = $urandom;
         end
         check_wb(inst, res, err, fwd);
         check("rdy_ret", bus_if.ma_rdy, 1'b1);
      end
      if ($urandom_range(0, 3) == 0) begin
         step();
         check("wb_pulse", bus_if.wb_vld, 1'b0);
         check("wb_hold", bus_if.wb_dat, res);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_rdy", bus_if.ma_rdy, 1'b1);
      check("rst_req", bus_if.dm_req, 1'b0);
      check("rst_we", bus_if.dm_we, 1'b0);
      check("rst_addr", bus_if.dm_addr, 32'd0);
      check("rst_be", bus_if.dm_be, 4'd0);
      check("rst_wdat", bus_if.dm_wdat, 32'd0);
      check("rst_wbv", bus_if.wb_vld, 1'b0);
      check("rst_wbi", bus_if.wb_inst, 32'd0);
      check("rst_wbd", bus_if.wb_dat, 32'd0);
      check("rst_wbe", bus_if.wb_err, 1'b0);
      check("rst_fwe", bus_if.id_fwd_we, 1'b0);
      check("rst_fdst", bus_if.id_fwd_dst, 5'd0);
      check("rst_fdat", bus_if.id_fwd_dat, 32'd0);
   endtask

   initial begin
      logic [31:0] i_a, i_l, i_b, a_a, a_b;
      logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst_n          = 1'b0;
      bus_if.ma_vld  = 1'b0;
      bus_if.ma_inst = '0;
      bus_if.ma_dat  = '0;
      bus_if.ma_rd2  = '0;
      bus_if.dm_gnt  = 1'b0;
      bus_if.dm_rvld = 1'b0;
      bus_if.dm_rdat = '0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      do_op(mk_inst(OP_ALUI, 3'd0, 5'd5), 32'h1234, 32'h0, 0, 0, 32'h0);
      do_op(mk_inst(OP_LOAD, 3'd0, 5'd3), 32'h1003, 32'h0, 0, 1, 32'h80FF_0000);
      do_op(mk_inst(OP_LOAD, 3'd4, 5'd3), 32'h1003, 32'h0, 0, 1, 32'h80FF_0000);
      do_op(mk_inst(OP_STORE, 3'd1, 5'd9), 32'h2002, 32'hABCD_1234, 3, 0, 32'h0);
      do_op(mk_inst(OP_LOAD, 3'd2, 5'd7), 32'h0006, 32'h0, 0, 0, 32'h0);
      do_op(mk_inst(OP_BRANCH, 3'd1, 5'd4), 32'h40, 32'h0, 0, 0, 32'h0);

      // Randomized mix.
      for (int n = 0; n < 200; n++) begin
         logic [6:0]  op;
         logic [2:0]  f3;
         logic [31:0] adr;
         int          kind;
         kind = $urandom_range(0, 3);
         f3   = 3'($urandom);
         case (kind)
            0:       op = ($urandom_range(0, 1) == 0) ? OP_ALUI : OP_ALU;
            1: begin op = OP_LOAD;  f3 = lf3[$urandom_range(0, 4)]; end
            2: begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
            default: op = OP_BRANCH;
         endcase
         adr = $urandom;
         if ($urandom_range(0, 2) != 0) adr[1:0] = (f3[1:0] == 2'd0) ? adr[1:0] :
                                                    (f3[1:0] == 2'd1) ? {adr[1], 1'b0} : 2'b00;
         do_op(mk_inst(op, f3, 5'($urandom)), adr, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom);
      end

      // Back-to-back ADD, LW, ADD with ma_vld held high.
      i_a = mk_inst(OP_ALU, 3'd0, 5'd1);
      i_l = mk_inst(OP_LOAD, 3'd2, 5'd2);
      i_b = mk_inst(OP_ALU, 3'd0, 5'd3);
      a_a = $urandom;
      a_b = $urandom;
      bus_if.ma_vld  = 1'b1;
      bus_if.ma_inst = i_a;
      bus_if.ma_dat  = a_a;
      step();
      check_wb(i_a, a_a, 1'b0, 1'b1);
      bus_if.ma_inst = i_l;
      bus_if.ma_dat  = 32'h0000_0100;
      step();
      check("b2b_req", bus_if.dm_req, 1'b1);
      check("b2b_rdy", bus_if.ma_rdy, 1'b0);
      bus_if.ma_inst = i_b;
      bus_if.ma_dat  = a_b;
      bus_if.dm_gnt  = 1'b1;
      step();
      bus_if.dm_gnt  = 1'b0;
      check("b2b_wbv", bus_if.wb_vld, 1'b0);
      bus_if.dm_rvld = 1'b1;
      bus_if.dm_rdat = 32'hCAFE_F00D;
      step();
      bus_if.dm_rvld = 1'b0;
      check_wb(i_l, 32'hCAFE_F00D, 1'b0, 1'b1);
      check("b2b_rdy2", bus_if.ma_rdy, 1'b1);
      step();
      bus_if.ma_vld = 1'b0;
      check_wb(i_b, a_b, 1'b0, 1'b1);
      step();
      check("b2b_end", bus_if.wb_vld, 1'b0);

      // Reset while waiting for read data.
      bus_if.ma_vld  = 1'b1;
      bus_if.ma_inst = mk_inst(OP_LOAD, 3'd2, 5'd6);
      bus_if.ma_dat  = 32'h0000_0200;
      step();
      bus_if.ma_vld = 1'b0;
      bus_if.dm_gnt = 1'b1;
      step();
      bus_if.dm_gnt = 1'b0;
      check("pre_rst_rdy", bus_if.ma_rdy, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_if.dm_rvld = 1'b1;
      bus_if.dm_rdat = 32'h1111_2222;
      step();
      bus_if.dm_rvld = 1'b0;
      check_reset_vals();
      step();
      check("post_rst_wbv", bus_if.wb_vld, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/memaccess_top.md
# memaccess_top

Memory-access stage of the etcpu pipeline. Sits between execute and writeback, consuming the execute stage's instruction, ALU result and rd2 operand. Performs loads and stores over a req/grant/read-valid data-memory port. Stalls upstream while an access is outstanding, then presents one registered writeback beat and an MA-stage forwarding interface to decode.

## Interface
Parameters:
- none; datapath is fixed at 32 bits, byte-addressed, 4 byte lanes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ma_vld  in  1  execute-side beat valid
- ma_rdy  out  1  stage can accept a beat
- ma_inst  in  32  instruction
- ma_dat  in  32  ALU result (effective address for load/store)
- ma_rd2  in  32  store data
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  32  word-aligned address ({ma_dat[31:2],2'b00})
- dm_be  out  4  byte enables
- dm_wdat  out  32  write data, lane-replicated
- dm_gnt  in  1  request accepted this cycle
- dm_rvld  in  1  read data valid
- dm_rdat  in  32  read data
- wb_vld  out  1  one-cycle retire pulse
- wb_inst  out  32  retired instruction
- wb_dat  out  32  result (load data or ALU result)
- wb_err  out  1  misaligned access flag, qualified by wb_vld
- id_fwd_we  out  1  forwarding write enable to decode
- id_fwd_dst  out  5  forwarding destination register
- id_fwd_dat  out  32  forwarding data

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011. funct3 = inst[14:12].
- FSM states:
  - IDLE: ma_rdy=1.
    - Accept on ma_vld&ma_rdy.
    - Non-memory op: stays IDLE; wb regs load {inst, ma_dat, err=0}.
    - Aligned load/store: goes to REQ, capturing inst, address, be and wdat.
  - REQ: dm_req=1, outputs held stable until dm_gnt.
    - On gnt, store: retire, go to IDLE.
    - On gnt, load: go to WAIT.
    - dm_rvld is ignored in REQ.
  - WAIT: on dm_rvld, extract load data, retire, go to IDLE.
- Load extraction, using offset = addr[1:0]:
  - LB 000: sign-extended byte.
  - LH 001: sign-extended half.
  - LW 010: word.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended half.
- Store encoding:
  - SB: be = 0001<<addr[1:0], wdat = {4{rd2[7:0]}}.
  - SH: be = 0011<<addr[1:0], wdat = {2{rd2[15:0]}}.
  - SW: be = 1111, wdat = rd2.
- Misaligned access:
  - Definition: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request; retires from IDLE like a non-memory op.
  - wb_err=1, wb_dat=0.
- Forwarding (combinational from wb regs):
  - id_fwd_we = wb_vld & ~store & ~branch & ~wb_err & (rd!=0).
  - id_fwd_dst = wb_inst[11:7].
  - id_fwd_dat = wb_dat.
- wb_inst, wb_dat and wb_err hold their values between pulses.

## Timing
- Reset: state IDLE; every output is 0 except ma_rdy, which is 1.
- Reset mid-access drops the request immediately; a later dm_rvld arriving in IDLE is ignored.
- Non-memory or misaligned op accepted at cycle T: wb_vld at T+1. Throughput is 1 per cycle.
- Memory op accepted at T:
  - dm_req rises at T+1.
  - ma_rdy=0 from T+1 until the retire cycle.
  - Store with gnt at G: wb_vld at G+1, ma_rdy=1 at G+1.
  - Load with gnt at G and rvld at R>G: wb_vld at R+1, ma_rdy=1 at R+1.
- Minimum latency: store 2 cycles (gnt at T+1); load 3 cycles (rvld at T+2).
- A new beat may be accepted in the same cycle wb_vld is asserted.
- dm_rvld coinciding with dm_gnt in REQ is a protocol violation; the block does not sample it.

## Test plan
- Reset then ADDI x5 with ma_dat=0x1234 -> wb_vld at T+1, wb_dat=0x1234, id_fwd_we=1, id_fwd_dst=5.
- LB x3, addr 0x1003, dm_gnt at T+1, rvld at T+3 with rdat=0x80FF_0000 -> dm_addr=0x1000, wb_dat=0xFFFF_FF80 at T+4; LBU same case -> 0x0000_0080.
- SH addr 0x2002, rd2=0xABCD_1234, gnt delayed 3 cycles -> dm_be=1100, dm_wdat=0x1234_1234, dm_req held stable, ma_rdy=0 until retire, id_fwd_we=0.
- LW addr 0x0006 -> no dm_req, wb_vld at T+1 with wb_err=1, wb_dat=0, id_fwd_we=0.
- Back-to-back ADD, LW, ADD with ma_vld held high -> second ADD accepted on the LW retire cycle; three consecutive wb pulses in order.
- rst_n dropped while in WAIT, then rvld pulsed after release -> no wb_vld, ma_rdy=1, all outputs at reset values.
